rclas_pipe: RTL and testbench

- Pipelined 16-bit recursive carry-lookahead subtractor. It computes diff = a - b - bin. This is the subtract direction of the datapath's 16-bit recursive lookahead adder.
- Uses the same kill/propagate/generate recursive-doubling prefix: 4 rows of span 1, 2, 4 and 8.
- Each prefix row is registered, and operands and results move over valid/ready handshakes.
- Sits between the operand staging logic and the compare/ALU result mux. It supplies the difference, the unsigned borrow and the signed flags.

---
 rtl/rclas_pipe.sv | 134 +++++++++++++
 tb/tb_rclas_pipe.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/rclas_pipe.sv
// Pipelined 16-bit recursive carry-lookahead subtractor: diff = a - b - bin.
// Kill/propagate/generate prefix of spans 1, 2, 4, 8; every row registered behind a global valid/ready stall.
module rclas_pipe #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:1]   a,
  input  logic [WIDTH:1]   b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:1]   diff,
  output logic             borrow,
  output logic             zero,
  output logic             ovf
);

  localparam int unsigned NROW = 4;

  logic [WIDTH-1:0] g_q [NROW];
  logic [WIDTH-1:0] g_d [NROW];
  logic [WIDTH-1:0] p_q [NROW];
  logic [WIDTH-1:0] p_d [NROW];
  logic [WIDTH-1:0] h_q [NROW];
  logic [WIDTH-1:0] h_d [NROW];
  logic [NROW-1:0]  c0_q, c0_d;
  logic [NROW:0]    valid_q, valid_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;

  logic             adv;
  logic             c0_in;
  logic [WIDTH-1:0] g_in, p_in, h_in;
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] diff_x;

  function automatic logic [WIDTH-1:0] row_g(input logic [WIDTH-1:0] g,
                                             input logic [WIDTH-1:0] p,
                                             input int unsigned span);
    row_g = g;
    for (int unsigned i = span; i < WIDTH; i++) row_g[i] = g[i] | (p[i] & g[i-span]);
  endfunction

  function automatic logic [WIDTH-1:0] row_p(input logic [WIDTH-1:0] p,
                                             input int unsigned span);
    row_p = p;
    for (int unsigned i = span; i < WIDTH; i++) row_p[i] = p[i] & p[i-span];
  endfunction

  always_comb begin
    adv      = ~valid_q[NROW] | out_ready;
    in_ready = adv & ~flush;

    // Carry-in is folded into bit 0 up front, so the prefix yields true carries with no extra row.
    c0_in   = ~bin;
    g_in    = a & ~b;
    p_in    = a | ~b;
    h_in    = a ^ ~b;
    g_in[0] = g_in[0] | (p_in[0] & c0_in);
    p_in[0] = 1'b0;

    carry    = row_g(g_q[NROW-1], p_q[NROW-1], 8);
    diff_x   = h_q[NROW-1] ^ {carry[WIDTH-2:0], c0_q[NROW-1]};

    g_d      = g_q;
    p_d      = p_q;
    h_d      = h_q;
    c0_d     = c0_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;

    if (adv) begin
      g_d[0]  = g_in;
      p_d[0]  = p_in;
      h_d[0]  = h_in;
      c0_d[0] = c0_in;
      for (int unsigned s = 1; s < NROW; s++) begin
        g_d[s]  = row_g(g_q[s-1], p_q[s-1], 1 << (s - 1));
        p_d[s]  = row_p(p_q[s-1], 1 << (s - 1));
        h_d[s]  = h_q[s-1];
        c0_d[s] = c0_q[s-1];
      end
      diff_d   = diff_x;
      borrow_d = ~carry[WIDTH-1];
      zero_d   = ~|diff_x;
      ovf_d    = carry[WIDTH-1] ^ carry[WIDTH-2];
    end

    if (flush)    valid_d = '0;
    else if (adv) valid_d = {valid_q[NROW-1:0], in_valid & in_ready};
    else          valid_d = valid_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < NROW; s++) begin
        g_q[s] <= '0;
        p_q[s] <= '0;
        h_q[s] <= '0;
      end
      c0_q     <= '0;
      valid_q  <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      g_q      <= g_d;
      p_q      <= p_d;
      h_q      <= h_d;
      c0_q     <= c0_d;
      valid_q  <= valid_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

  assign out_valid = valid_q[NROW];
  assign diff      = diff_q;
  assign borrow    = borrow_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_rclas_pipe.sv
// Directed self-checking bench for rclas_pipe; inputs driven and outputs sampled on the falling edge.
module tb_rclas_pipe;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, bin;
  logic [16:1] a, b, diff;
  logic        out_valid, out_ready, borrow, zero, ovf;

  typedef struct {
    logic [15:0] diff;
    logic        borrow;
    logic        zero;
    logic        ovf;
    logic        lat;
    int          acc_cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t pend;
  int   checks = 0, errors = 0;
  int   cyc = 0, delivered = 0;
  bit   head_seen = 0, acc = 0;
  bit   sched_on = 0;
  int   sched_cnt = 0;

  rclas_pipe #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin),
    .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .borrow(borrow), .zero(zero), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  // One clock cycle: settle, score the output side, record an accept, cross the edge.
  task automatic step();
    if (sched_on) begin
      out_ready = !(sched_cnt >= 6 && sched_cnt <= 8);
      sched_cnt++;
    end
    #1;
    acc = in_valid && in_ready;
    if (out_valid) begin
      if (exp_q.size() == 0) check("spurious_valid", {31'd0, out_valid}, 32'd0);
      else begin
        if (!head_seen) begin
          head_seen = 1;
          if (exp_q[0].lat) check("latency", cyc - exp_q[0].acc_cyc, 4);
        end
        check("diff",   {16'd0, diff},   {16'd0, exp_q[0].diff});
        check("borrow", {31'd0, borrow}, {31'd0, exp_q[0].borrow});
        check("zero",   {31'd0, zero},   {31'd0, exp_q[0].zero});
        check("ovf",    {31'd0, ovf},    {31'd0, exp_q[0].ovf});
        if (!out_ready) check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        else begin
          void'(exp_q.pop_front());
          head_seen = 0;
          delivered++;
        end
      end
    end
    if (acc) begin
      pend.acc_cyc = cyc + 1;
      exp_q.push_back(pend);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic drive_op(input logic [15:0] av, input logic [15:0] bv, input logic bi,
                          input logic [15:0] d, input logic bo, input logic z,
                          input logic o, input logic lat);
    int n = 0;
    a = av; b = bv; bin = bi; in_valid = 1'b1;
    pend.diff = d; pend.borrow = bo; pend.zero = z; pend.ovf = o; pend.lat = lat;
    acc = 0;
    while (!acc && n < 50) begin
      step();
      n++;
    end
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      step();
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    int d0;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; bin = 1'b0;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_diff",      {16'd0, diff},      32'd0);
    check("rst_flags",     {29'd0, borrow, zero, ovf}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Isolated directed vectors, each latency-checked.
    drive_op(16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b1); drain();
    drive_op(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1); drain();
    drive_op(16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1); drain();
    drive_op(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b1, 1'b1); drain();
    drive_op(16'h1234, 16'h1233, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1); drain();
    drive_op(16'hABCD, 16'hABCD, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1); drain();
    drive_op(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b1); drain();

    // Back-to-back stream with a 3-cycle output stall.
    d0 = delivered;
    sched_on = 1; sched_cnt = 0;
    drive_op(16'h1111, 16'd1, 1'b0, 16'h1110, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_op(16'h2222, 16'd2, 1'b0, 16'h2220, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_op(16'h3333, 16'd3, 1'b0, 16'h3330, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_op(16'h4444, 16'd4, 1'b0, 16'h4440, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_op(16'h5555, 16'd5, 1'b0, 16'h5550, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_op(16'h6666, 16'd6, 1'b0, 16'h6660, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_op(16'h7777, 16'd7, 1'b0, 16'h7770, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_op(16'h8888, 16'd8, 1'b0, 16'h8880, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();
    sched_on = 0; out_ready = 1'b1;
    check("stream_count", delivered - d0, 8);

    // Asynchronous reset with four transactions in flight.
    drive_op(16'h0100, 16'h0001, 1'b0, 16'h00FF, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_op(16'h0200, 16'h0001, 1'b0, 16'h01FF, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_op(16'h0300, 16'h0001, 1'b0, 16'h02FF, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_op(16'h0400, 16'h0001, 1'b0, 16'h03FF, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_diff",      {16'd0, diff},      32'd0);
    check("midrst_in_ready",  {31'd0, in_ready},  32'd1);
    exp_q.delete(); head_seen = 0;
    @(posedge clk); @(negedge clk);
    check("midrst_hold_valid", {31'd0, out_valid}, 32'd0);
    rst_n = 1'b1;
    repeat (6) step();
    drive_op(16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0, 1'b0, 1'b1);
    drain();

    // Flush with three in flight and a simultaneous offer.
    drive_op(16'h0A00, 16'h0001, 1'b0, 16'h09FF, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_op(16'h0B00, 16'h0001, 1'b0, 16'h0AFF, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_op(16'h0C00, 16'h0001, 1'b0, 16'h0BFF, 1'b0, 1'b0, 1'b0, 1'b0);
    flush = 1'b1; in_valid = 1'b1; a = 16'hDEAD; b = 16'h0001; bin = 1'b0;
    #1 check("flush_in_ready", {31'd0, in_ready}, 32'd0);
    exp_q.delete(); head_seen = 0;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("post_flush_valid", {31'd0, out_valid}, 32'd0);
    repeat (8) step();
    check("flush_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
